// File: rtl/write_buffer_nline.sv
// write_buffer_nline: DEPTH-entry circular write buffer of dirty cache lines.
// Accepts masked line writes, merges into non-head entries, forwards buffered
// words to read probes (youngest entry wins per word) and drains in FIFO
// order to the AXI write master. The head entry is locked while it is offered.
module write_buffer_nline #(
  parameter int DEPTH      = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wreq_i,
  input  logic [31:0]                waddr_i,
  input  logic [32*LINE_WORDS-1:0]   wdata_i,
  input  logic [LINE_WORDS-1:0]      wsel_i,
  output logic                       wready_o,
  input  logic                       rreq_i,
  input  logic [31:0]                raddr_i,
  output logic                       rhit_o,
  output logic [32*LINE_WORDS-1:0]   rdata_o,
  output logic [LINE_WORDS-1:0]      rmask_o,
  input  logic                       flush_i,
  output logic                       flush_done_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [31:0]                m_addr_o,
  output logic [32*LINE_WORDS-1:0]   m_data_o,
  output logic [LINE_WORDS-1:0]      m_strb_o
);

  localparam int OFS = $clog2(LINE_WORDS * 4);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int LW  = 32 * LINE_WORDS;

  logic [DEPTH-1:0]      r_valid;
  logic [31:0]           r_addr [DEPTH];
  logic [LW-1:0]         r_data [DEPTH];
  logic [LINE_WORDS-1:0] r_mask [DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  logic [31:0]   w_wline;
  logic [31:0]   w_rline;
  logic          w_wmatch;
  logic [PW-1:0] w_widx;
  logic          w_rh_head;
  logic          w_rh_other;
  logic [PW-1:0] w_ridx;
  logic          w_accept;
  logic          w_alloc;
  logic          w_merge;
  logic          w_pop;
  logic          w_unused_ok;

  assign w_wline = {waddr_i[31:OFS], {OFS{1'b0}}};
  assign w_rline = {raddr_i[31:OFS], {OFS{1'b0}}};
  assign w_unused_ok = ^{waddr_i[OFS-1:0], raddr_i[OFS-1:0]};

  assign empty_o      = (r_count == '0);
  assign full_o       = (r_count == CW'(DEPTH));
  assign count_o      = r_count;
  assign m_valid_o    = !empty_o;
  assign m_addr_o     = r_addr[r_head];
  assign m_data_o     = r_data[r_head];
  assign m_strb_o     = r_mask[r_head];
  assign flush_done_o = flush_i && empty_o;

  // Find the single non-head entry holding the written line (merge target).
  always_comb begin
    w_wmatch = 1'b0;
    w_widx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (PW'(i) != r_head) && (r_addr[i] == w_wline)) begin
        w_wmatch = 1'b1;
        w_widx   = PW'(i);
      end
    end
  end

  assign wready_o = !flush_i && (!full_o || w_wmatch);
  assign w_accept = wreq_i && wready_o && (wsel_i != '0);
  assign w_merge  = w_accept && w_wmatch;
  assign w_alloc  = w_accept && !w_wmatch;
  assign w_pop    = m_valid_o && m_ready_i;

  assign w_rh_head = !empty_o && (r_addr[r_head] == w_rline);

  // Read forwarding: non-head (younger) words override the head word by word.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    w_rh_other = 1'b0;
    w_ridx     = '0;
    rhit_o     = 1'b0;
    rdata_o    = '0;
    rmask_o    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (PW'(i) != r_head) && (r_addr[i] == w_rline)) begin
        w_rh_other = 1'b1;
        w_ridx     = PW'(i);
      end
    end
    if (rreq_i && (w_rh_head || w_rh_other)) begin
      rhit_o = 1'b1;
      if (w_rh_head) begin
        rdata_o = r_data[r_head];
        rmask_o = r_mask[r_head];
      end
      if (w_rh_other) begin
        rmask_o = rmask_o | r_mask[w_ridx];
        for (int w = 0; w < LINE_WORDS; w++) begin
          if (r_mask[w_ridx][w]) rdata_o[w*32 +: 32] = r_data[w_ridx][w*32 +: 32];
        end
      end
    end
  end

  // Control state: valid bits, pointers and occupancy.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      r_count <= r_count + CW'(w_alloc) - CW'(w_pop);
    end
  end

  // Entry payload: allocate at tail or merge selected words into the match.
  always_ff @(posedge clk) begin
    // NOTE: payload arrays carry no reset; the valid bits alone qualify them.
    if (w_alloc) begin
      r_addr[r_tail] <= w_wline;
      r_data[r_tail] <= wdata_i;
      r_mask[r_tail] <= wsel_i;
    end else if (w_merge) begin
      for (int w = 0; w < LINE_WORDS; w++) begin
        if (wsel_i[w]) begin
          r_data[w_widx][w*32 +: 32] <= wdata_i[w*32 +: 32];
          r_mask[w_widx][w]          <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_write_buffer_nline.sv
// tb_write_buffer_nline: directed scenarios plus randomized traffic, all
// compared every cycle against a queue-based model of the write buffer.
module tb_write_buffer_nline;

  localparam int DEPTH = 4;
  localparam int LINE_WORDS = 4;
  localparam int LW = 32 * LINE_WORDS;

  typedef struct {
    logic [31:0]           addr;
    logic [LW-1:0]         data;
    logic [LINE_WORDS-1:0] mask;
  } ent_t;

  logic clk = 1'b0;
  logic rst, wreq, wready, rreq, rhit, flush, flush_done, full, empty;
  logic m_valid, m_ready;
  logic [31:0] waddr, raddr, m_addr;
  logic [LW-1:0] wdata, rdata, m_data;
  logic [LINE_WORDS-1:0] wsel, rmask, m_strb;
  logic [$clog2(DEPTH):0] count;

  ent_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  write_buffer_nline #(.DEPTH(DEPTH), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk), .rst(rst),
    .wreq_i(wreq), .waddr_i(waddr), .wdata_i(wdata), .wsel_i(wsel), .wready_o(wready),
    .rreq_i(rreq), .raddr_i(raddr), .rhit_o(rhit), .rdata_o(rdata), .rmask_o(rmask),
    .flush_i(flush), .flush_done_o(flush_done), .full_o(full), .empty_o(empty),
    .count_o(count), .m_valid_o(m_valid), .m_ready_i(m_ready), .m_addr_o(m_addr),
    .m_data_o(m_data), .m_strb_o(m_strb)
  );

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & 32'hFFFF_FFF0;
  endfunction

  function automatic logic [LW-1:0] expand(input logic [LINE_WORDS-1:0] m);
    logic [LW-1:0] r;
    for (int w = 0; w < LINE_WORDS; w++) r[w*32 +: 32] = {32{m[w]}};
    return r;
  endfunction

  function automatic int match_nonhead(input logic [31:0] a);
    int mi = -1;
    for (int i = 1; i < q.size(); i++) if (q[i].addr == line_of(a)) mi = i;
    return mi;
  endfunction

  // Compare every output against the model for the current inputs.
  task automatic check_outputs();
    int sz = q.size();
    int ho;
    bit hh;
    logic [LINE_WORDS-1:0] em;
    logic [LW-1:0] ed;
    check("count", LW'(count), LW'(sz));
    check("empty", LW'(empty), LW'(sz == 0));
    check("full", LW'(full), LW'(sz == DEPTH));
    check("m_valid", LW'(m_valid), LW'(sz != 0));
    check("wready", LW'(wready), LW'(!flush && (sz < DEPTH || match_nonhead(waddr) >= 0)));
    check("flush_done", LW'(flush_done), LW'(flush && sz == 0));
    if (sz > 0) begin
      check("m_addr", LW'(m_addr), LW'(q[0].addr));
      check("m_data", m_data, q[0].data);
      check("m_strb", LW'(m_strb), LW'(q[0].mask));
    end
    hh = (sz > 0) && (q[0].addr == line_of(raddr));
    ho = match_nonhead(raddr);
    em = '0;
    ed = '0;
    if (rreq && (hh || ho >= 0)) begin
      if (hh) em = q[0].mask;
      if (ho >= 0) em = em | q[ho].mask;
      for (int w = 0; w < LINE_WORDS; w++) begin
        if (ho >= 0 && q[ho].mask[w]) ed[w*32 +: 32] = q[ho].data[w*32 +: 32];
        else if (hh) ed[w*32 +: 32] = q[0].data[w*32 +: 32];
      end
      check("rhit", LW'(rhit), LW'(1));
      check("rmask", LW'(rmask), LW'(em));
      check("rdata", rdata & expand(em), ed & expand(em));
    end else begin
      check("rhit", LW'(rhit), LW'(0));
      check("rmask", LW'(rmask), LW'(0));
      check("rdata", rdata, '0);
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_update();
    int mi;
    bit acc, pop;
    ent_t e;
    if (!rst) begin
      q.delete();
      return;
    end
    mi  = match_nonhead(waddr);
    acc = wreq && !flush && (q.size() < DEPTH || mi >= 0) && (wsel != '0);
    pop = (q.size() > 0) && m_ready;
    if (acc && mi >= 0) begin
      for (int w = 0; w < LINE_WORDS; w++) begin
        if (wsel[w]) begin
          q[mi].data[w*32 +: 32] = wdata[w*32 +: 32];
          q[mi].mask[w] = 1'b1;
        end
      end
    end
    if (pop) void'(q.pop_front());
    if (acc && mi < 0) begin
      e.addr = line_of(waddr);
      e.data = wdata;
      e.mask = wsel;
      q.push_back(e);
    end
  endtask

  // Called at a falling edge with inputs already set.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    wreq = 1'b0; rreq = 1'b0; wsel = '0; waddr = '0; raddr = '0; wdata = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [LINE_WORDS-1:0] s, input logic [LW-1:0] d);
    wreq = 1'b1; waddr = a; wsel = s; wdata = d;
  endtask

  initial begin
    int first;
    logic [LW-1:0] rd;
    rst = 1'b0; flush = 1'b0; m_ready = 1'b0;
    idle();
    @(posedge clk);
    q.delete();
    @(negedge clk);
    tick();
    #1;
    check("rst_count", LW'(count), LW'(0));
    check("rst_wready", LW'(wready), LW'(1));
    rst = 1'b1;

    // Allocate, head lock, merge and forwarding combine.
    wr(32'h1000_0004, 4'b0001, {32'h0, 32'h0, 32'h0, 32'hAAAA_0001});
    tick();
    wr(32'h1000_0008, 4'b0010, {32'h0, 32'h0, 32'hBBBB_0002, 32'h0});
    #1;
    check("alloc_count", LW'(count), LW'(1));
    check("alloc_addr", LW'(m_addr), LW'(32'h1000_0000));
    check("alloc_strb", LW'(m_strb), LW'(4'b0001));
    tick();
    wr(32'h1000_0000, 4'b0100, {32'h0, 32'hCCCC_0003, 32'h0, 32'h0});
    tick();
    idle();
    rreq = 1'b1; raddr = 32'h1000_0000;
    #1;
    check("merge_count", LW'(count), LW'(2));
    check("head_strb", LW'(m_strb), LW'(4'b0001));
    check("fwd_mask", LW'(rmask), LW'(4'b0111));
    rd = rdata;
    check("fwd_w0", LW'(rd[31:0]), LW'(32'hAAAA_0001));
    check("fwd_w2", LW'(rd[95:64]), LW'(32'hCCCC_0003));
    tick();

    // Full, stall on new line, merge while full, release after a pop.
    wr(32'h2000_0000, 4'b1111, {4{32'h2222_2222}}); tick();
    wr(32'h3000_0000, 4'b1111, {4{32'h3333_3333}}); tick();
    wr(32'h4000_0000, 4'b1111, {4{32'h4444_4444}});
    #1;
    check("full_flag", LW'(full), LW'(1));
    check("full_stall", LW'(wready), LW'(0));
    tick();
    wr(32'h1000_0000, 4'b1000, {32'h1111_0004, 96'h0}); tick();
    idle(); m_ready = 1'b1; tick();
    m_ready = 1'b0;
    wr(32'h4000_0000, 4'b1111, {4{32'h4444_4444}});
    #1;
    check("pop_release", LW'(wready), LW'(1));
    tick();

    // Simultaneous allocate + pop across pointer wrap.
    idle(); rst = 1'b0; tick(); rst = 1'b1;
    wr(32'h5000_0000, 4'b0011, {4{32'h5555_0000}}); tick();
    wr(32'h5000_0010, 4'b0011, {4{32'h5555_0010}}); tick();
    m_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      wr(32'h6000_0000 + 32'(i) * 32'h10, 4'b1111, {4{$urandom()}});
      tick();
      check("aloc_pop_count", LW'(count), LW'(2));
    end
    idle();
    m_ready = 1'b0;
    rst = 1'b0; tick(); rst = 1'b1;

    // Flush with three entries draining one per cycle.
    wr(32'h7000_0000, 4'b0001, {4{32'h7}}); tick();
    wr(32'h7100_0000, 4'b0001, {4{32'h71}}); tick();
    wr(32'h7200_0000, 4'b0001, {4{32'h72}}); tick();
    wr(32'h7300_0000, 4'b0001, {4{32'h73}});
    flush = 1'b1; m_ready = 1'b1;
    first = -1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (flush_done && first < 0) first = k;
      tick();
    end
    check("flush_latency", LW'(first), LW'(3));
    flush = 1'b0; m_ready = 1'b0;

    // Reset mid-drain.
    wr(32'h8000_0000, 4'b1111, {4{32'h8}}); tick();
    wr(32'h8100_0000, 4'b1111, {4{32'h81}}); tick();
    idle(); m_ready = 1'b1; tick();
    rst = 1'b0; tick();
    rst = 1'b1; m_ready = 1'b0;
    #1;
    check("rst_drain_empty", LW'(empty), LW'(1));
    check("rst_drain_valid", LW'(m_valid), LW'(0));
    tick();

    // Randomized traffic over a small pool of lines to provoke merges/hits.
    for (int c = 0; c < 4000; c++) begin
      rst     = ($urandom_range(0, 199) != 0);
      wreq    = ($urandom_range(0, 9) < 7);
      waddr   = (32'($urandom_range(1, 6)) << 12) | 32'($urandom_range(0, 15));
      wsel    = 4'($urandom());
      wdata   = {$urandom(), $urandom(), $urandom(), $urandom()};
      rreq    = ($urandom_range(0, 1) == 1);
      raddr   = (32'($urandom_range(1, 6)) << 12) | 32'($urandom_range(0, 15));
      m_ready = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 49) == 0) flush = ~flush;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
